// File: rtl/mem_port_arbiter_pkg.sv
// Shared bus widths, arbiter state encoding and timeout default for the
// instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_BUS    = 32;
    localparam int unsigned DATA_BUS    = 32;
    localparam int unsigned MEM_SEL_BUS = 4;

    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_D_BUSY  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_t;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Bus-access watchdog: counts busy cycles without an acknowledge and pulses
// expire on the cycle that would reach the TIMEOUT limit.
module arb_timeout_cnt #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // Fires during the TIMEOUT-th unacknowledged busy cycle.
    assign expire = enable && !clear && (count == TIMEOUT - 8'd1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-port memory with
// alternating priority under contention, flush discard and a bus timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [ADDR_BUS-1:0]    if_addr,
    output logic [DATA_BUS-1:0]    if_rdata,
    output logic                   if_ready,
    input  logic                   d_req,
    input  logic [MEM_SEL_BUS-1:0] d_we,
    input  logic [ADDR_BUS-1:0]    d_addr,
    input  logic [DATA_BUS-1:0]    d_wdata,
    output logic [DATA_BUS-1:0]    d_rdata,
    output logic                   d_ready,
    input  logic                   flush,
    output logic                   mem_req,
    output logic [MEM_SEL_BUS-1:0] mem_we,
    output logic [ADDR_BUS-1:0]    mem_addr,
    output logic [DATA_BUS-1:0]    mem_wdata,
    input  logic [DATA_BUS-1:0]    mem_rdata,
    input  logic                   mem_ack,
    output logic                   stall_pc,
    output logic                   stall_mem,
    output logic                   bus_err
);

    arb_state_t state, next_state;
    grant_t     last_grant;
    logic       discard;
    logic       cnt_clear;
    logic       cnt_enable;
    logic       expire;

    arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A ready pulse means the requester still holds its request this cycle,
    // so no grant is made until the following cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (!if_ready && !d_ready) begin
                    if (d_req && (last_grant == GRANT_IF || !if_req)) begin
                        next_state = ST_D_BUSY;
                    end else if (if_req) begin
                        next_state = ST_IF_BUSY;
                    end
                end
            end
            ST_IF_BUSY, ST_D_BUSY: begin
                if (mem_ack || expire) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_clear  = (state == ST_IDLE);
        cnt_enable = (state != ST_IDLE) && !mem_ack;
        bus_err    = expire;
        stall_pc   = if_req && !if_ready;
        stall_mem  = d_req && !d_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= GRANT_IF;
            discard    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    discard <= 1'b0;
                    if (next_state == ST_D_BUSY) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (next_state == ST_IF_BUSY) begin
                        mem_req   <= 1'b1;
                        mem_we    <= '0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                ST_IF_BUSY: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        last_grant <= GRANT_IF;
                        discard    <= 1'b0;
                        if (!(discard || flush)) begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                    end else if (expire) begin
                        mem_req <= 1'b0;
                        discard <= 1'b0;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                ST_D_BUSY: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        last_grant <= GRANT_D;
                        d_ready    <= 1'b1;
                        if (mem_we == '0) begin
                            d_rdata <= mem_rdata;
                        end
                    end else if (expire) begin
                        mem_req <= 1'b0;
                    end
                end
                default: mem_req <= 1'b0;
            endcase
        end
    end

endmodule
